processor_core: RTL and testbench

PROCESSOR_CORE -- requirements
Module: processor_core

---
 rtl/proc_pkg.sv | 40 ++++
 rtl/alu.sv | 30 +++
 rtl/processor_core.sv | 81 ++++++++
 tb/tb_processor_core.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: instruction field positions, opcode/aluop codes and special register indices.
package proc_pkg;
    localparam int OPC_LSB = 27;
    localparam int RD_LSB = 22;
    localparam int RS_LSB = 17;
    localparam int RT_LSB = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;
    localparam int IMM_W = 17;
    localparam int TGT_W = 27;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [4:0] REG_LINK = 5'd31;

    typedef enum logic [4:0] {
        OP_RTYPE = 5'd0,
        OP_J = 5'd1,
        OP_BNE = 5'd2,
        OP_JAL = 5'd3,
        OP_JR = 5'd4,
        OP_ADDI = 5'd5,
        OP_BLT = 5'd6,
        OP_SW = 5'd7,
        OP_LW = 5'd8,
        OP_SETX = 5'd21,
        OP_BEX = 5'd22
    } opcode_t;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR = 5'd3,
        ALU_SLL = 5'd4,
        ALU_SRA = 5'd5
    } aluop_t;

    function automatic logic [31:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/alu.sv
// alu: 32-bit arithmetic/logic unit with equality, signed-less-than and overflow flags.
module alu
    import proc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        ne,
    output logic        lt,
    output logic        ovf
);
    logic [31:0] sum, diff;
    logic signed [31:0] sra;
    assign sum = a + b;
    assign diff = a - b;
    assign sra = $signed(a) >>> shamt;
    assign result = op == ALU_ADD ? sum :
                    op == ALU_SUB ? diff :
                    op == ALU_AND ? a & b :
                    op == ALU_OR  ? a | b :
                    op == ALU_SLL ? a << shamt :
                    op == ALU_SRA ? sra : 32'd0;
    // overflow: result sign disagrees with what the operand signs allow
    assign ovf = op == ALU_ADD ? (a[31] == b[31] && sum[31] != a[31]) :
                 op == ALU_SUB ? (a[31] != b[31] && diff[31] != a[31]) : 1'b0;
    assign ne = a != b;
    assign lt = $signed(a) < $signed(b);
endmodule

// File: rtl/processor_core.sv
// processor_core: single-cycle core; instruction/data memories and register file are external.
module processor_core
    import proc_pkg::*;
#(
    parameter logic [11:0] RESET_PC = 12'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] address_imem,
    input  logic [31:0] q_imem,
    output logic [11:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB
);
    logic [11:0] pc, pc_inc, next_pc;
    logic [4:0] opcode, rd, rs, rt, shamt, aluop, alu_op;
    logic [31:0] imm, target, alu_a, alu_b, alu_result;
    logic ne, lt, ovf, r_type, valid_alu, swap, wr_req, ovf_hit;
    logic unused;

    assign opcode = q_imem[OPC_LSB +: 5];
    assign rd = q_imem[RD_LSB +: 5];
    assign rs = q_imem[RS_LSB +: 5];
    assign rt = q_imem[RT_LSB +: 5];
    assign shamt = q_imem[SHAMT_LSB +: 5];
    assign aluop = q_imem[ALUOP_LSB +: 5];
    assign imm = sext_imm(q_imem[IMM_W-1:0]);
    assign target = {{(32-TGT_W){1'b0}}, q_imem[TGT_W-1:0]};
    assign unused = ^q_imem[1:0];

    assign r_type = opcode == OP_RTYPE;
    assign valid_alu = r_type && aluop <= ALU_SRA;
    // compare-style instructions put rd on port A so rd is the left operand
    assign swap = opcode inside {OP_BNE, OP_BLT, OP_JR, OP_SW};
    assign ctrl_readRegA = opcode == OP_BEX ? REG_STATUS : swap ? rd : rs;
    assign ctrl_readRegB = swap ? rs : rt;

    assign alu_a = opcode == OP_SW ? data_readRegB : data_readRegA;
    assign alu_b = (r_type || opcode inside {OP_BNE, OP_BLT}) ? data_readRegB : imm;
    assign alu_op = r_type ? aluop : ALU_ADD;

    alu u_alu (
        .a(alu_a),
        .b(alu_b),
        .op(alu_op),
        .shamt(shamt),
        .result(alu_result),
        .ne(ne),
        .lt(lt),
        .ovf(ovf)
    );

    assign pc_inc = pc + 12'd1;
    assign next_pc = (opcode == OP_J || opcode == OP_JAL || (opcode == OP_BEX && data_readRegA != 32'd0)) ? target[11:0] :
                     opcode == OP_JR ? data_readRegA[11:0] :
                     ((opcode == OP_BNE && ne) || (opcode == OP_BLT && lt)) ? pc_inc + imm[11:0] : pc_inc;

    assign wr_req = valid_alu || opcode inside {OP_ADDI, OP_LW, OP_JAL, OP_SETX};
    assign ovf_hit = ovf && (r_type || opcode == OP_ADDI);
    assign ctrl_writeReg = (ovf_hit || opcode == OP_SETX) ? REG_STATUS : opcode == OP_JAL ? REG_LINK : rd;
    assign data_writeReg = ovf_hit ? (r_type ? (aluop == ALU_ADD ? 32'd1 : 32'd3) : 32'd2) :
                           opcode == OP_LW ? q_dmem :
                           opcode == OP_JAL ? {20'd0, pc_inc} :
                           opcode == OP_SETX ? target : alu_result;
    assign ctrl_writeEnable = wr_req && ctrl_writeReg != 5'd0 && !reset;
    assign wren = opcode == OP_SW && !reset;

    assign address_imem = pc;
    assign address_dmem = alu_result[11:0];
    assign data = data_readRegA;

    always_ff @(posedge clock) pc <= reset ? RESET_PC : next_pc;
endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: directed checks plus a random program compared against an ISA-level model.
module tb_processor_core;
    localparam logic [11:0] RPC = 12'd4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [11:0] address_imem, address_dmem;
    logic [31:0] q_imem, data, q_dmem, data_writeReg, data_readRegA, data_readRegB;
    logic wren, ctrl_writeEnable;
    logic [4:0] ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;

    logic [31:0] imem [4096];
    logic [31:0] dmem [4096];
    logic [31:0] dm_ref [4096];
    logic [31:0] rf [32];
    logic [31:0] rf_ref [32];
    int pc_ref;
    int checks = 0;
    int errors = 0;

    assign q_imem = imem[address_imem];
    assign q_dmem = dmem[address_dmem];
    assign data_readRegA = rf[ctrl_readRegA];
    assign data_readRegB = rf[ctrl_readRegB];

    processor_core #(.RESET_PC(RPC)) dut (
        .clock(clock),
        .reset(reset),
        .address_imem(address_imem),
        .q_imem(q_imem),
        .address_dmem(address_dmem),
        .data(data),
        .wren(wren),
        .q_dmem(q_dmem),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg),
        .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // the external register file and data memory commit at the clock edge
    task automatic step();
        logic we, wm;
        logic [4:0] wr;
        logic [31:0] wd, sd;
        logic [11:0] wa;
        we = ctrl_writeEnable; wr = ctrl_writeReg; wd = data_writeReg;
        wm = wren; wa = address_dmem; sd = data;
        @(posedge clock);
        if (we) rf[wr] = wd;
        if (wm) dmem[wa] = sd;
        #1;
    endtask

    task automatic boot();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic clear();
        for (int i = 0; i < 4096; i++) begin
            imem[i] = 32'd0;
            dmem[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    endtask

    function automatic logic [31:0] rins(input int rd, input int rs, input int rt, input int sh, input int fn);
        return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(fn), 2'd0};
    endfunction

    function automatic logic [31:0] iins(input int op, input int rd, input int rs, input int imm);
        return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
    endfunction

    function automatic logic [31:0] jins(input int op, input int t);
        return {5'(op), 27'(t)};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        int ops [13] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22, 31};
        w = $urandom;
        w[31:27] = 5'(ops[$urandom_range(0, 12)]);
        if (w[31:27] == 5'd0) w[6:2] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic wr_ref(input int r, input logic [31:0] v);
        if (r != 0) rf_ref[r] = v;
    endtask

    // instruction-set model: one instruction from imem at pc_ref, plain integer arithmetic
    task automatic ref_exec();
        logic [31:0] ins;
        int op, rd, rs, rt, sh, fn, imm, t, a, b, d, npc;
        longint s;
        ins = imem[pc_ref[11:0]];
        op = int'(ins[31:27]); rd = int'(ins[26:22]); rs = int'(ins[21:17]);
        rt = int'(ins[16:12]); sh = int'(ins[11:7]); fn = int'(ins[6:2]);
        imm = int'($signed(ins[16:0]));
        t = int'(ins[26:0]);
        a = rf_ref[rs]; b = rf_ref[rt]; d = rf_ref[rd];
        npc = (pc_ref + 1) % 4096;
        case (op)
            0: case (fn)
                0: begin s = longint'(a) + longint'(b); if (s != longint'(int'(s))) wr_ref(30, 1); else wr_ref(rd, int'(s)); end
                1: begin s = longint'(a) - longint'(b); if (s != longint'(int'(s))) wr_ref(30, 3); else wr_ref(rd, int'(s)); end
                2: wr_ref(rd, a & b);
                3: wr_ref(rd, a | b);
                4: wr_ref(rd, a << sh);
                5: wr_ref(rd, a >>> sh);
                default: ;
            endcase
            5: begin s = longint'(a) + longint'(imm); if (s != longint'(int'(s))) wr_ref(30, 2); else wr_ref(rd, int'(s)); end
            7: dm_ref[(a + imm) & 4095] = d;
            8: wr_ref(rd, dm_ref[(a + imm) & 4095]);
            1: npc = t & 4095;
            2: if (d != a) npc = (pc_ref + 1 + imm) & 4095;
            3: begin wr_ref(31, npc); npc = t & 4095; end
            4: npc = d & 4095;
            6: if (d < a) npc = (pc_ref + 1 + imm) & 4095;
            21: wr_ref(30, t);
            22: if (rf_ref[30] != 0) npc = t & 4095;
            default: ;
        endcase
        pc_ref = npc;
    endtask

    function automatic int rf_diff();
        int n = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== rf_ref[i]) n++;
        return n;
    endfunction

    function automatic int dm_diff();
        int n = 0;
        for (int i = 0; i < 4096; i++) if (dmem[i] !== dm_ref[i]) n++;
        return n;
    endfunction

    initial begin
        // reset gating and addi
        clear();
        imem[RPC] = iins(5, 1, 0, 5);
        imem[RPC + 1] = iins(5, 0, 0, 5);
        reset = 1'b1;
        step();
        chk("rst_pc", 32'(address_imem), 32'(RPC));
        chk("rst_we", 32'(ctrl_writeEnable), 0);
        chk("rst_wren", 32'(wren), 0);
        step();
        reset = 1'b0;
        #1;
        chk("addi_we", 32'(ctrl_writeEnable), 1);
        chk("addi_reg", 32'(ctrl_writeReg), 1);
        chk("addi_data", data_writeReg, 5);
        step();
        chk("addi_rf", rf[1], 5);
        chk("r0_we", 32'(ctrl_writeEnable), 0);

        // overflow redirects, invalid aluop, shifts
        clear();
        rf[5] = 32'h7fffffff; rf[6] = 1; rf[8] = 32'h80000000;
        imem[4] = rins(7, 5, 6, 0, 0);
        imem[5] = rins(7, 8, 6, 0, 1);
        imem[6] = iins(5, 7, 5, 1);
        imem[7] = rins(9, 5, 6, 0, 6);
        imem[8] = rins(10, 8, 0, 4, 5);
        imem[9] = rins(11, 6, 0, 31, 4);
        boot();
        chk("add_ovf_reg", 32'(ctrl_writeReg), 30);
        chk("add_ovf_data", data_writeReg, 1);
        step();
        chk("sub_ovf_reg", 32'(ctrl_writeReg), 30);
        chk("sub_ovf_data", data_writeReg, 3);
        step();
        chk("addi_ovf_reg", 32'(ctrl_writeReg), 30);
        chk("addi_ovf_data", data_writeReg, 2);
        step();
        chk("bad_aluop_we", 32'(ctrl_writeEnable), 0);
        step();
        chk("sra_data", data_writeReg, 32'hf8000000);
        step();
        chk("sll_data", data_writeReg, 32'h80000000);

        // store then load
        clear();
        rf[3] = 8; rf[2] = 32'hab;
        imem[4] = iins(7, 2, 3, 4);
        imem[5] = iins(8, 4, 3, 4);
        boot();
        chk("sw_wren", 32'(wren), 1);
        chk("sw_addr", 32'(address_dmem), 12);
        chk("sw_data", data, 32'hab);
        chk("sw_we", 32'(ctrl_writeEnable), 0);
        step();
        chk("sw_mem", dmem[12], 32'hab);
        chk("lw_wren", 32'(wren), 0);
        chk("lw_reg", 32'(ctrl_writeReg), 4);
        chk("lw_data", data_writeReg, 32'hab);

        // bne taken / not taken, blt signed
        clear();
        rf[1] = 1; rf[2] = 2;
        imem[4] = jins(1, 10);
        imem[10] = iins(2, 1, 2, -3);
        boot();
        step();
        chk("j_pc", 32'(address_imem), 10);
        step();
        chk("bne_taken", 32'(address_imem), 8);
        rf[2] = 1;
        boot();
        step();
        step();
        chk("bne_fall", 32'(address_imem), 11);
        clear();
        rf[1] = -1; rf[2] = 1;
        imem[4] = iins(6, 1, 2, 20);
        boot();
        chk("blt_portA", 32'(ctrl_readRegA), 1);
        step();
        chk("blt_taken", 32'(address_imem), 25);
        rf[1] = 1; rf[2] = -1;
        boot();
        step();
        chk("blt_fall", 32'(address_imem), 5);

        // jal / jr
        clear();
        imem[5] = jins(3, 100);
        imem[100] = iins(4, 31, 0, 0);
        boot();
        step();
        chk("jal_we", 32'(ctrl_writeEnable), 1);
        chk("jal_reg", 32'(ctrl_writeReg), 31);
        chk("jal_data", data_writeReg, 6);
        step();
        chk("jal_pc", 32'(address_imem), 100);
        chk("jr_portA", 32'(ctrl_readRegA), 31);
        step();
        chk("jr_pc", 32'(address_imem), 6);

        // setx / bex
        clear();
        imem[4] = jins(21, 7);
        imem[5] = jins(22, 50);
        boot();
        chk("setx_reg", 32'(ctrl_writeReg), 30);
        chk("setx_data", data_writeReg, 7);
        step();
        chk("bex_portA", 32'(ctrl_readRegA), 30);
        step();
        chk("bex_taken", 32'(address_imem), 50);
        clear();
        imem[4] = jins(22, 50);
        boot();
        step();
        chk("bex_fall", 32'(address_imem), 5);

        // PC wrap on sequential advance and on a backward branch
        clear();
        rf[1] = 1;
        imem[4] = jins(1, 27'h7fff000 + 4095);
        imem[0] = iins(2, 1, 0, -2);
        boot();
        step();
        chk("jmp_trunc", 32'(address_imem), 4095);
        step();
        chk("wrap_seq", 32'(address_imem), 0);
        step();
        chk("wrap_branch", 32'(address_imem), 4095);

        // random program against the ISA model, with a mid-program reset
        for (int i = 0; i < 4096; i++) begin
            imem[i] = rand_ins();
            dmem[i] = $urandom;
            dm_ref[i] = dmem[i];
        end
        boot();
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        for (int i = 0; i < 32; i++) rf_ref[i] = rf[i];
        pc_ref = RPC;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                imem[pc_ref] = iins(7, 1, 2, 0);
                reset = 1'b1;
                #1;
                chk("mid_rst_wren", 32'(wren), 0);
                step();
                imem[RPC] = iins(5, 1, 0, 5);
                #1;
                chk("mid_rst_we", 32'(ctrl_writeEnable), 0);
                step();
                reset = 1'b0;
                #1;
                pc_ref = RPC;
                chk("mid_rst_rf", 32'(rf_diff()), 0);
            end
            chk("rand_pc", 32'(address_imem), 32'(pc_ref));
            ref_exec();
            step();
            chk("rand_rf", 32'(rf_diff()), 0);
        end
        chk("rand_dmem", 32'(dm_diff()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
